// File: rtl/ph_cache_peak.sv
// ph_cache_peak: builds one peak-hold image per trigger for the
// pulse-height baseline stage.
//
// After a trigger the block waits for a start-of-frame, then for FRAMES
// frames keeps the unsigned per-pixel maximum of the incoming samples in
// a 2**ADDR_W-deep memory. ph_cache_valid is high while the capture runs.
// Its falling edge tells the baseline stage that the image is complete.
// The block then answers that stage's reads until 2**ADDR_W read strobes
// have been served, and returns to idle.
//
// Ports
//   clk, rst           single clock, synchronous active-high reset
//   trig               capture request (1-cycle pulse), dropped unless idle
//   pix_valid          sample strobe; pix_sof / pix_eof qualify frame limits
//   pix_addr/pix_data  pixel index and unsigned sample value
//   ph_cache_valid     high while a capture is in progress
//   ph_cache_enb       read strobe from the baseline stage
//   ph_cache_raddr     read address, sampled with ph_cache_enb
//   ph_cache_data      registered read data, one cycle after the strobe
//   busy               high whenever the state machine is not idle
//   trig_drop_cnt      saturating count of dropped triggers
//
// Build option
//   PH_CACHE_DROP_CNT_EN  when defined, trig_drop_cnt counts dropped
//                         triggers; otherwise it is tied to zero.
module ph_cache_peak #(
    parameter int FRAMES = 4,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trig,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic              pix_eof,
    input  logic [ADDR_W-1:0] pix_addr,
    input  logic [DATA_W-1:0] pix_data,
    output logic              ph_cache_valid,
    input  logic              ph_cache_enb,
    input  logic [ADDR_W-1:0] ph_cache_raddr,
    output logic [DATA_W-1:0] ph_cache_data,
    output logic              busy,
    output logic [15:0]       trig_drop_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [7:0]        FRM_LAST = 8'(FRAMES - 1);
    localparam logic [ADDR_W-1:0] ONE_A    = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_CAPTURE,
        S_DRAIN,
        S_READOUT
    } state_e;

    function automatic logic [DATA_W-1:0] umax(input logic [DATA_W-1:0] a,
                                               input logic [DATA_W-1:0] b);
        return (b > a) ? b : a;
    endfunction

    state_e            state_q, state_d;
    logic [7:0]        frm_q, frm_d;
    logic              drn_q, drn_d;
    logic [ADDR_W-1:0] rdcnt_q, rdcnt_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  touched_q;

    logic cap_start, acc_p0, eof_cnt, rd_hit;

    // The sof sample seen in ARM is itself part of the capture.
    assign cap_start = (state_q == S_ARM) && pix_valid && pix_sof;
    assign acc_p0    = pix_valid && ((state_q == S_CAPTURE) || cap_start);
    assign eof_cnt   = (state_q == S_CAPTURE) && pix_valid && pix_eof;
    assign rd_hit    = (state_q == S_READOUT) && ph_cache_enb;

    assign busy           = (state_q != S_IDLE);
    assign ph_cache_valid = (state_q == S_CAPTURE) || (state_q == S_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            frm_q   <= '0;
            drn_q   <= 1'b0;
            rdcnt_q <= '0;
        end else begin
            state_q <= state_d;
            frm_q   <= frm_d;
            drn_q   <= drn_d;
            rdcnt_q <= rdcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        frm_d   = frm_q;
        drn_d   = drn_q;
        rdcnt_d = rdcnt_q;
        case (state_q)
            S_IDLE: begin
                if (trig) state_d = S_ARM;
            end
            S_ARM: begin
                if (cap_start) begin
                    state_d = S_CAPTURE;
                    frm_d   = '0;
                end
            end
            S_CAPTURE: begin
                if (eof_cnt) begin
                    if (frm_q == FRM_LAST) begin
                        state_d = S_DRAIN;
                        drn_d   = 1'b0;
                    end else begin
                        frm_d = frm_q + 8'd1;
                    end
                end
            end
            S_DRAIN: begin
                // Two cycles let the last sample's read-modify-write land.
                if (drn_q) begin
                    state_d = S_READOUT;
                    rdcnt_d = '0;
                end else begin
                    drn_d = 1'b1;
                end
            end
            S_READOUT: begin
                if (rd_hit) begin
                    rdcnt_d = rdcnt_q + ONE_A;
                    if (rdcnt_q == '1) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // c0 -> c1: register the sample and the stored value at its address
    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [DATA_W-1:0] data_p1, rdat_p1;

    always_ff @(posedge clk) begin
        if (rst) vld_p1 <= 1'b0;
        else     vld_p1 <= acc_p0;
    end

    always_ff @(posedge clk) begin
        if (acc_p0) begin
            addr_p1 <= pix_addr;
            data_p1 <= pix_data;
            rdat_p1 <= mem[pix_addr];
        end
    end

    // c1 -> c2: merge, write back; c2 holds the write for forwarding
    logic              vld_p2;
    logic [ADDR_W-1:0] addr_p2;
    logic [DATA_W-1:0] wdat_p2;
    logic              fwd_p1, tch_p1;
    logic [DATA_W-1:0] base_p1, wdat_p1;

    // A back-to-back sample to the same pixel read the memory before the
    // previous write landed, so take the value being written instead.
    assign fwd_p1  = vld_p2 && (addr_p2 == addr_p1);
    assign base_p1 = fwd_p1 ? wdat_p2 : rdat_p1;
    assign tch_p1  = touched_q[addr_p1] || fwd_p1;
    assign wdat_p1 = tch_p1 ? umax(base_p1, data_p1) : data_p1;

    always_ff @(posedge clk) begin
        if (rst) vld_p2 <= 1'b0;
        else     vld_p2 <= vld_p1;
    end

    always_ff @(posedge clk) begin
        addr_p2 <= addr_p1;
        wdat_p2 <= wdat_p1;
    end

    always_ff @(posedge clk) begin
        if (vld_p1) mem[addr_p1] <= wdat_p1;
    end

    // The touched map, not the memory, is what makes untouched pixels
    // read as zero, so the memory itself is never cleared.
    always_ff @(posedge clk) begin
        if (rst || cap_start) touched_q <= '0;
        else if (vld_p1)      touched_q[addr_p1] <= 1'b1;
    end

    // Read port: a strobe outside READOUT answers zero.
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (ph_cache_enb) begin
            if (rd_hit && touched_q[ph_cache_raddr]) rd_data_q <= mem[ph_cache_raddr];
            else                                     rd_data_q <= '0;
        end
    end

    assign ph_cache_data = rd_data_q;

`ifdef PH_CACHE_DROP_CNT_EN
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] drop_q;

    always_ff @(posedge clk) begin
        if (rst)                           drop_q <= '0;
        else if (trig && state_q != S_IDLE) drop_q <= sat_inc16(drop_q);
    end

    assign trig_drop_cnt = drop_q;
`else
    assign trig_drop_cnt = '0;
`endif

endmodule
